gmii2fifo_pack: RTL and testbench



---
 rtl/gmii2fifo_pack.sv | 186 ++++++++++++++++++
 tb/tb_gmii2fifo_pack.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/gmii2fifo_pack.sv
// GMII receive front end: strips preamble/SFD, packs BYTES octets per FIFO word, appends GAP zero words.
// Optional macro RXER_DROP_EN adds gmii_rx_er and drops frames that carry a receive error.
module gmii2fifo_pack #(
   parameter int         BYTES = 1,
   parameter logic [3:0] GAP   = 4'h2
) (
   input  logic                 gmii_rx_clk,
   input  logic                 sys_rst_n,
   input  logic                 gmii_rx_dv,
   input  logic [7:0]           gmii_rxd,
`ifdef RXER_DROP_EN
   input  logic                 gmii_rx_er,
`endif
   output logic [9*BYTES-1:0]   din,
   input  logic                 full,
   output logic                 wr_en,
   output logic                 wr_clk,
   output logic [15:0]          frame_count,
   output logic [15:0]          drop_count
);

   localparam int LW = (BYTES > 1) ? $clog2(BYTES) : 1;

   typedef enum logic [1:0] {IDLE, DATA, DROP, GAP_ST} state_t;

   state_t                state, state_n;
   logic [LW-1:0]         lane_cnt, lane_n;
   logic [8*BYTES-1:0]    data_p0, data_n, lane_data;
   logic [BYTES-1:0]      mask_p0, mask_n, lane_mask;
   logic [3:0]            gap_cnt, gap_n;
   logic                  written, written_n;
   logic [9*BYTES-1:0]    din_n;
   logic                  wr_en_n, frame_inc, drop_inc, flushed, last_lane, rx_err;

`ifdef RXER_DROP_EN
   assign rx_err = gmii_rx_er;
`else
   assign rx_err = 1'b0;
`endif

   assign wr_clk = gmii_rx_clk;

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   // Merge the incoming byte into the lane selected by lane_cnt.
   always_comb begin
      lane_data = data_p0;
      lane_mask = mask_p0;
      for (int i = 0; i < BYTES; i++) begin
         if (LW'(i) == lane_cnt) begin
            lane_data[8*i +: 8] = gmii_rxd;
            lane_mask[i]        = 1'b1;
         end
      end
   end

   assign last_lane = (lane_cnt == LW'(BYTES-1));

   always_comb begin
      state_n   = state;
      lane_n    = lane_cnt;
      data_n    = data_p0;
      mask_n    = mask_p0;
      gap_n     = gap_cnt;
      written_n = written;
      din_n     = din;
      wr_en_n   = 1'b0;
      frame_inc = 1'b0;
      drop_inc  = 1'b0;
      flushed   = 1'b0;
      case (state)
         IDLE, GAP_ST: begin
            // A byte arriving during the gap abandons it and is judged as in IDLE.
            if (gmii_rx_dv) begin
               if (gmii_rxd == 8'hD5) begin
                  state_n   = DATA;
                  lane_n    = '0;
                  data_n    = '0;
                  mask_n    = '0;
                  written_n = 1'b0;
               end else if (state == GAP_ST) begin
                  state_n   = IDLE;
                  written_n = 1'b0;
               end
            end else if (state == GAP_ST && !full) begin
               din_n   = '0;
               wr_en_n = 1'b1;
               gap_n   = gap_cnt - 4'd1;
               if (gap_cnt == 4'd1) begin
                  state_n   = IDLE;
                  written_n = 1'b0;
               end
            end
         end
         DATA: begin
            if (gmii_rx_dv) begin
               if (rx_err) begin
                  state_n  = DROP;
                  drop_inc = 1'b1;
                  lane_n   = '0;
                  data_n   = '0;
                  mask_n   = '0;
               end else if (last_lane) begin
                  lane_n = '0;
                  data_n = '0;
                  mask_n = '0;
                  if (full) begin
                     state_n  = DROP;
                     drop_inc = 1'b1;
                  end else begin
                     din_n     = {lane_mask, lane_data};
                     wr_en_n   = 1'b1;
                     written_n = 1'b1;
                  end
               end else begin
                  lane_n = lane_cnt + 1'b1;
                  data_n = lane_data;
                  mask_n = lane_mask;
               end
            end else begin
               lane_n = '0;
               data_n = '0;
               mask_n = '0;
               if (lane_cnt != '0) begin
                  if (full) begin
                     drop_inc = 1'b1;
                  end else begin
                     din_n     = {mask_p0, data_p0};
                     wr_en_n   = 1'b1;
                     frame_inc = 1'b1;
                     flushed   = 1'b1;
                  end
               end else if (written) begin
                  frame_inc = 1'b1;
               end
               if ((written || flushed) && GAP != 4'd0) begin
                  state_n = GAP_ST;
                  gap_n   = GAP;
               end else begin
                  state_n = IDLE;
               end
            end
         end
         DROP: begin
            if (!gmii_rx_dv) begin
               if (written && GAP != 4'd0) begin
                  state_n = GAP_ST;
                  gap_n   = GAP;
               end else begin
                  state_n = IDLE;
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge gmii_rx_clk) begin
      if (!sys_rst_n) begin
         state       <= IDLE;
         lane_cnt    <= '0;
         data_p0     <= '0;
         mask_p0     <= '0;
         gap_cnt     <= '0;
         written     <= 1'b0;
         wr_en       <= 1'b0;
         din         <= '0;
         frame_count <= '0;
         drop_count  <= '0;
      end else begin
         state    <= state_n;
         lane_cnt <= lane_n;
         data_p0  <= data_n;
         mask_p0  <= mask_n;
         gap_cnt  <= gap_n;
         written  <= written_n;
         wr_en    <= wr_en_n;
         din      <= din_n;
         if (frame_inc) frame_count <= sat_inc(frame_count);
         if (drop_inc)  drop_count  <= sat_inc(drop_count);
      end
   end

endmodule

// File: tb/tb_gmii2fifo_pack.sv
// Directed bench for gmii2fifo_pack: three instances (BYTES=4/GAP=2, BYTES=1/GAP=2, BYTES=2/GAP=3).
module tb_gmii2fifo_pack;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic        dv_a, full_a, wr_en_a, wclk_a;
   logic [7:0]  rxd_a;
   logic [35:0] din_a;
   logic [15:0] fc_a, dc_a;
   logic        er_a;

   logic        dv_b, full_b, wr_en_b, wclk_b;
   logic [7:0]  rxd_b;
   logic [8:0]  din_b;
   logic [15:0] fc_b, dc_b;

   logic        dv_c, full_c, wr_en_c, wclk_c;
   logic [7:0]  rxd_c;
   logic [17:0] din_c;
   logic [15:0] fc_c, dc_c;

   gmii2fifo_pack #(.BYTES(4), .GAP(4'h2)) dut_a (
      .gmii_rx_clk(clk), .sys_rst_n(rst_n), .gmii_rx_dv(dv_a), .gmii_rxd(rxd_a),
`ifdef RXER_DROP_EN
      .gmii_rx_er(er_a),
`endif
      .din(din_a), .full(full_a), .wr_en(wr_en_a), .wr_clk(wclk_a),
      .frame_count(fc_a), .drop_count(dc_a));

   gmii2fifo_pack #(.BYTES(1), .GAP(4'h2)) dut_b (
      .gmii_rx_clk(clk), .sys_rst_n(rst_n), .gmii_rx_dv(dv_b), .gmii_rxd(rxd_b),
`ifdef RXER_DROP_EN
      .gmii_rx_er(1'b0),
`endif
      .din(din_b), .full(full_b), .wr_en(wr_en_b), .wr_clk(wclk_b),
      .frame_count(fc_b), .drop_count(dc_b));

   gmii2fifo_pack #(.BYTES(2), .GAP(4'h3)) dut_c (
      .gmii_rx_clk(clk), .sys_rst_n(rst_n), .gmii_rx_dv(dv_c), .gmii_rxd(rxd_c),
`ifdef RXER_DROP_EN
      .gmii_rx_er(1'b0),
`endif
      .din(din_c), .full(full_c), .wr_en(wr_en_c), .wr_clk(wclk_c),
      .frame_count(fc_c), .drop_count(dc_c));

   logic [35:0] qa[$];
   logic [8:0]  qb[$];
   logic [17:0] qc[$];

   // Collect every FIFO write, sampled away from the active edge.
   always @(negedge clk) begin
      if (wr_en_a) qa.push_back(din_a);
      if (wr_en_b) qb.push_back(din_b);
      if (wr_en_c) qc.push_back(din_c);
   end

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
         $error("check %s", tag);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_a(input logic dv, input logic [7:0] b);
      dv_a  = dv;
      rxd_a = b;
      tick();
   endtask

   initial begin
      rst_n = 1'b0;
      dv_a = 0; rxd_a = 0; full_a = 0; er_a = 0;
      dv_b = 0; rxd_b = 0; full_b = 0;
      dv_c = 0; rxd_c = 0; full_c = 0;
      tick(); tick();
      chk("rst_wr_en", 64'(wr_en_a), 64'd0);
      chk("rst_din", 64'(din_a), 64'd0);
      chk("rst_frame_count", 64'(fc_a), 64'd0);
      chk("rst_drop_count", 64'(dc_a), 64'd0);
      rst_n = 1'b1;
      tick();

      // Preamble, SFD, six bytes into a 4-lane word
      for (int i = 0; i < 7; i++) drive_a(1'b1, 8'h55);
      drive_a(1'b1, 8'hD5);
      for (int i = 1; i <= 3; i++) drive_a(1'b1, 8'(i));
      chk("w4_no_early_write", 64'(wr_en_a), 64'd0);
      drive_a(1'b1, 8'h04);
      chk("w4_wr_en_timing", 64'(wr_en_a), 64'd1);
      chk("w4_din_timing", 64'(din_a), 64'hF_04030201);
      drive_a(1'b1, 8'h05);
      drive_a(1'b1, 8'h06);
      drive_a(1'b0, 8'h00);
      repeat (4) tick();
      chk("w4_nwrites", 64'(qa.size()), 64'd4);
      chk("w4_word0", 64'(qa[0]), 64'hF_04030201);
      chk("w4_flush", 64'(qa[1]), 64'h3_00000605);
      chk("w4_gap0", 64'(qa[2]), 64'd0);
      chk("w4_gap1", 64'(qa[3]), 64'd0);
      chk("w4_frame_count", 64'(fc_a), 64'd1);
      chk("w4_drop_count", 64'(dc_a), 64'd0);

      // Legacy 9-bit stream
      dv_b = 1; rxd_b = 8'hD5; tick();
      rxd_b = 8'hAA; tick();
      rxd_b = 8'hBB; tick();
      dv_b = 0; rxd_b = 8'h00;
      repeat (4) tick();
      chk("w1_nwrites", 64'(qb.size()), 64'd4);
      chk("w1_word0", 64'(qb[0]), 64'h1AA);
      chk("w1_word1", 64'(qb[1]), 64'h1BB);
      chk("w1_gap0", 64'(qb[2]), 64'h000);
      chk("w1_gap1", 64'(qb[3]), 64'h000);
      chk("w1_frame_count", 64'(fc_b), 64'd1);

      // Overflow: full from byte 5 on, gap stalls until full drops
      qa.delete();
      drive_a(1'b1, 8'hD5);
      for (int i = 1; i <= 12; i++) begin
         if (i == 5) full_a = 1'b1;
         drive_a(1'b1, 8'(i));
      end
      drive_a(1'b0, 8'h00);
      repeat (3) tick();
      chk("ovf_stalled_writes", 64'(qa.size()), 64'd1);
      chk("ovf_drop_count", 64'(dc_a), 64'd1);
      full_a = 1'b0;
      repeat (4) tick();
      chk("ovf_nwrites", 64'(qa.size()), 64'd3);
      chk("ovf_word0", 64'(qa[0]), 64'hF_04030201);
      chk("ovf_gap0", 64'(qa[1]), 64'd0);
      chk("ovf_gap1", 64'(qa[2]), 64'd0);
      chk("ovf_frame_count", 64'(fc_a), 64'd1);

      // Second frame cuts the gap short after one zero word
      dv_c = 1; rxd_c = 8'hD5; tick();
      rxd_c = 8'h01; tick();
      rxd_c = 8'h02; tick();
      dv_c = 0; rxd_c = 8'h00; tick();
      tick();
      dv_c = 1; rxd_c = 8'hD5; tick();
      rxd_c = 8'h11; tick();
      rxd_c = 8'h22; tick();
      dv_c = 0; rxd_c = 8'h00;
      repeat (5) tick();
      chk("gapcut_nwrites", 64'(qc.size()), 64'd6);
      chk("gapcut_word0", 64'(qc[0]), 64'h3_0201);
      chk("gapcut_gap0", 64'(qc[1]), 64'd0);
      chk("gapcut_word1", 64'(qc[2]), 64'h3_2211);
      chk("gapcut_tail", 64'(qc[3]) | 64'(qc[4]) | 64'(qc[5]), 64'd0);
      chk("gapcut_frame_count", 64'(fc_c), 64'd2);

      // Reset lands on the edge that would have written a word
      qa.delete();
      drive_a(1'b1, 8'hD5);
      for (int i = 1; i <= 3; i++) drive_a(1'b1, 8'(i));
      rst_n = 1'b0;
      drive_a(1'b1, 8'h04);
      chk("midrst_wr_en", 64'(wr_en_a), 64'd0);
      chk("midrst_frame_count", 64'(fc_a), 64'd0);
      chk("midrst_drop_count", 64'(dc_a), 64'd0);
      rst_n = 1'b1;
      for (int i = 5; i <= 8; i++) drive_a(1'b1, 8'(i));
      drive_a(1'b0, 8'h00);
      repeat (3) tick();
      chk("midrst_ignored", 64'(qa.size()), 64'd0);
      drive_a(1'b1, 8'hD5);
      for (int i = 1; i <= 4; i++) drive_a(1'b1, 8'hA0 + 8'(i));
      drive_a(1'b0, 8'h00);
      repeat (3) tick();
      chk("midrst_new_nwrites", 64'(qa.size()), 64'd3);
      chk("midrst_new_word", 64'(qa[0]), 64'hF_A4A3A2A1);
      chk("midrst_new_frame_count", 64'(fc_a), 64'd1);

`ifdef RXER_DROP_EN
      // Error before any word written: no gap
      qa.delete();
      drive_a(1'b1, 8'hD5);
      drive_a(1'b1, 8'h01);
      drive_a(1'b1, 8'h02);
      er_a = 1'b1;
      drive_a(1'b1, 8'h03);
      er_a = 1'b0;
      drive_a(1'b1, 8'h04);
      drive_a(1'b0, 8'h00);
      repeat (3) tick();
      chk("rxer_nowrite", 64'(qa.size()), 64'd0);
      chk("rxer_drop1", 64'(dc_a), 64'd1);
      // Error after a word was written: two gap words follow
      drive_a(1'b1, 8'hD5);
      for (int i = 1; i <= 5; i++) drive_a(1'b1, 8'(i));
      er_a = 1'b1;
      drive_a(1'b1, 8'h06);
      er_a = 1'b0;
      drive_a(1'b0, 8'h00);
      repeat (3) tick();
      chk("rxer_nwrites", 64'(qa.size()), 64'd3);
      chk("rxer_word0", 64'(qa[0]), 64'hF_04030201);
      chk("rxer_gap", 64'(qa[1]) | 64'(qa[2]), 64'd0);
      chk("rxer_drop2", 64'(dc_a), 64'd2);
      chk("rxer_frame_count", 64'(fc_a), 64'd1);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
